// File: rtl/idma_obi_sram_bridge_pkg.sv
// Shared types and helpers for the OBI-to-SRAM bridge and its response FIFO.
// obi_sram_rsp_t matches the bridge's default widths; the top re-declares it for other widths.
package idma_obi_sram_bridge_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultIdWidth   = 1;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] rdata;
    logic [DefaultIdWidth-1:0]   rid;
    logic                        err;
  } obi_sram_rsp_t;

  // Occupancy counters must be able to represent "full", hence depth+1 states.
  function automatic int unsigned rsp_count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/idma_obi_sram_rsp_fifo.sv
// Small response FIFO with registered head (no fall-through); supports any depth >= 2.
module idma_obi_sram_rsp_fifo
  import idma_obi_sram_bridge_pkg::*;
#(
  parameter type data_t = obi_sram_rsp_t,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrWidth   = $clog2(Depth),
  localparam int unsigned CountWidth = rsp_count_width(Depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  data_t                 push_data,
  input  logic                  pop,
  output data_t                 pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  data_t               mem [Depth];
  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;

  // Explicit wrap keeps non-power-of-2 depths inside the storage array.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: ;
      endcase
    end
  end

  assign pop_data = mem[rptr];
  assign full     = (count == CountWidth'(Depth));
  assign empty    = (count == '0);

endmodule

// File: rtl/idma_obi_sram_bridge.sv
// OBI subordinate terminating reads/writes on a 1-cycle-latency SRAM; responses are
// buffered in a FIFO and the A-channel grant is throttled by free FIFO credit.
module idma_obi_sram_bridge
  import idma_obi_sram_bridge_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned IdWidth       = 1,
  parameter int unsigned SramAddrWidth = 10,
  parameter int unsigned RspDepth      = 2,
  parameter int unsigned StrbWidth     = DataWidth / 8,
  parameter int unsigned OffsetWidth   = $clog2(StrbWidth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     obi_req_a_req_i,
  input  logic [AddrWidth-1:0]     obi_req_a_addr_i,
  input  logic                     obi_req_a_we_i,
  input  logic [StrbWidth-1:0]     obi_req_a_be_i,
  input  logic [DataWidth-1:0]     obi_req_a_wdata_i,
  input  logic [IdWidth-1:0]       obi_req_a_aid_i,
  input  logic                     obi_req_r_ready_i,
  output logic                     obi_rsp_a_gnt_o,
  output logic                     obi_rsp_r_valid_o,
  output logic [DataWidth-1:0]     obi_rsp_r_rdata_o,
  output logic [IdWidth-1:0]       obi_rsp_r_rid_o,
  output logic                     obi_rsp_r_err_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [StrbWidth-1:0]     sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i,
  output logic                     busy_o
);

  localparam int unsigned CountWidth = rsp_count_width(RspDepth);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } rsp_t;

  logic                  out_en;
  logic                  oob;
  logic                  accept;
  logic                  credit_ok;
  logic                  pop;
  logic                  rsp_valid;
  logic [CountWidth:0]   occupancy;
  logic                  s1_valid;
  logic                  s1_we;
  logic                  s1_oob;
  logic [IdWidth-1:0]    s1_aid;
  rsp_t                  push_data;
  rsp_t                  head;
  logic                  full;
  logic                  empty;
  logic [CountWidth-1:0] count;

  assign oob = (obi_req_a_addr_i >> (OffsetWidth + SramAddrWidth)) != '0;

  // Responses already owed (buffered + in stage 1), minus the one leaving this cycle.
  assign occupancy = {1'b0, count} + (CountWidth + 1)'(s1_valid) - (CountWidth + 1)'(pop);
  assign credit_ok = occupancy < (CountWidth + 1)'(RspDepth);

  assign obi_rsp_a_gnt_o = out_en && obi_req_a_req_i && credit_ok;
  assign accept          = obi_rsp_a_gnt_o;

  assign sram_req_o   = accept && !oob;
  assign sram_we_o    = sram_req_o && obi_req_a_we_i;
  assign sram_addr_o  = sram_req_o ? obi_req_a_addr_i[OffsetWidth +: SramAddrWidth] : '0;
  assign sram_be_o    = sram_req_o ? obi_req_a_be_i : '0;
  assign sram_wdata_o = sram_req_o ? obi_req_a_wdata_i : '0;

  // out_en keeps the grant low through reset and the first cycle after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_oob   <= 1'b0;
      s1_aid   <= '0;
    end else begin
      out_en   <= 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_we  <= obi_req_a_we_i;
        s1_oob <= oob;
        s1_aid <= obi_req_a_aid_i;
      end
    end
  end

  assign push_data.rdata = (s1_we || s1_oob) ? '0 : sram_rdata_i;
  assign push_data.rid   = s1_aid;
  assign push_data.err   = s1_oob;

  idma_obi_sram_rsp_fifo #(
    .data_t (rsp_t),
    .Depth  (RspDepth)
  ) i_rsp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (s1_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rsp_valid = !empty;
  assign pop       = rsp_valid && obi_req_r_ready_i;

  assign obi_rsp_r_valid_o = rsp_valid;
  assign obi_rsp_r_rdata_o = rsp_valid ? head.rdata : '0;
  assign obi_rsp_r_rid_o   = rsp_valid ? head.rid : '0;
  assign obi_rsp_r_err_o   = rsp_valid && head.err;

  assign busy_o = s1_valid || (count != '0);

  // Credit accounting must make a push into a full FIFO impossible.
  assert property (@(posedge clk_i) disable iff (rst_i) !(s1_valid && full));

endmodule

// File: tb/tb_idma_obi_sram_bridge.sv
// Self-checking bench: table-driven OBI transactions with a response scoreboard,
// plus hand-written back-pressure and reset sequences.
module tb_idma_obi_sram_bridge;
  import idma_obi_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [0:0]  aid;
  logic        r_ready;
  logic        gnt;
  logic        r_valid;
  logic [31:0] rdata;
  logic [0:0]  rid;
  logic        err;
  logic        sram_req;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        busy;

  always #5 clk = ~clk;

  idma_obi_sram_bridge dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .obi_req_a_req_i   (req),
    .obi_req_a_addr_i  (addr),
    .obi_req_a_we_i    (we),
    .obi_req_a_be_i    (be),
    .obi_req_a_wdata_i (wdata),
    .obi_req_a_aid_i   (aid),
    .obi_req_r_ready_i (r_ready),
    .obi_rsp_a_gnt_o   (gnt),
    .obi_rsp_r_valid_o (r_valid),
    .obi_rsp_r_rdata_o (rdata),
    .obi_rsp_r_rid_o   (rid),
    .obi_rsp_r_err_o   (err),
    .sram_req_o        (sram_req),
    .sram_we_o         (sram_we),
    .sram_addr_o       (sram_addr),
    .sram_wdata_o      (sram_wdata),
    .sram_be_o         (sram_be),
    .sram_rdata_i      (sram_rdata),
    .busy_o            (busy)
  );

  // SRAM macro model: byte-enabled writes, 1-cycle read latency.
  logic [31:0] sram [1024];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  obi_sram_rsp_t sb[$];
  int            pop_cyc[$];
  obi_sram_rsp_t mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every handshake on R is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && r_valid && r_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected response: rdata 0x%0h rid %0d with empty scoreboard", rdata, rid);
      end else begin
        mon_exp = sb.pop_front();
        check("rsp rdata", rdata, mon_exp.rdata);
        check("rsp rid", 32'(rid), 32'(mon_exp.rid));
        check("rsp err", 32'(err), 32'(mon_exp.err));
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d, input logic id,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.addr = a; v.we = w; v.be = b; v.wdata = d; v.aid = id;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge, req left high.
  task automatic issue(input vec_t v, input bit must_gnt, output int t);
    int waited;
    waited = 0;
    req = 1'b1; addr = v.addr; we = v.we; be = v.be; wdata = v.wdata; aid = v.aid;
    @(negedge clk);
    while (!gnt && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    t = cyc;
    if (!gnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant timeout: addr 0x%0h never granted", v.addr);
    end else begin
      if (must_gnt) check("gnt without stall", waited, 0);
      check("sram_req", 32'(sram_req), 32'(!v.exp_err));
      if (!v.exp_err) begin
        check("sram_we", 32'(sram_we), 32'(v.we));
        check("sram_addr", 32'(sram_addr), 32'(v.addr[11:2]));
        check("sram_be", 32'(sram_be), 32'(v.be));
        check("sram_wdata", sram_wdata, v.wdata);
      end else begin
        check("sram_be oob", 32'(sram_be), 0);
      end
      sb.push_back('{rdata: v.exp_rdata, rid: v.aid, err: v.exp_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || r_valid || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain timeout: busy %0d, %0d responses outstanding", busy, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic run_single(input vec_t v, input string name);
    int t;
    pop_cyc.delete();
    issue(v, 1'b1, t);
    req = 1'b0;
    wait_idle();
    check(name, (pop_cyc.size() == 1) ? 32'(pop_cyc[0] - t) : 32'hFFFF_FFFF, 2);
  endtask

  vec_t tbl [13];
  vec_t rd8 [8];

  initial begin
    int t;
    int t0;
    int grants;

    tbl[0]  = mk(32'h0000_0020, 1, 4'h3, 32'hAABB_CCDD, 1, 32'h0,         0);
    tbl[1]  = mk(32'h0000_0020, 0, 4'hF, 32'h0,         0, 32'h0000_CCDD, 0);
    tbl[2]  = mk(32'h0000_0022, 1, 4'hC, 32'h1122_3344, 0, 32'h0,         0);
    tbl[3]  = mk(32'h0000_0023, 0, 4'hF, 32'h0,         1, 32'h1122_CCDD, 0);
    tbl[4]  = mk(32'h0000_1000, 1, 4'hF, 32'h1234_5678, 1, 32'h0,         1);
    tbl[5]  = mk(32'h0000_1000, 0, 4'hF, 32'h0,         0, 32'h0,         1);
    tbl[6]  = mk(32'h0000_0FFC, 1, 4'hF, 32'hCAFE_F00D, 0, 32'h0,         0);
    tbl[7]  = mk(32'h0000_0FFC, 0, 4'hF, 32'h0,         1, 32'hCAFE_F00D, 0);
    tbl[8]  = mk(32'h8000_0010, 0, 4'hF, 32'h0,         0, 32'h0,         1);
    tbl[9]  = mk(32'h0000_0010, 0, 4'hF, 32'h0,         1, 32'hDEAD_BEEF, 0);
    tbl[10] = mk(32'h0000_0014, 1, 4'h1, 32'hFFFF_FF5A, 0, 32'h0,         0);
    tbl[11] = mk(32'h0000_0014, 0, 4'hF, 32'h0,         0, 32'h0000_005A, 0);
    tbl[12] = mk(32'h0000_0000, 0, 4'hF, 32'h0,         1, 32'h0,         0);

    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0:       rd8[k] = mk(32'h10,  0, 4'hF, 0, 1'(k / 4),      32'hDEAD_BEEF, 0);
        1:       rd8[k] = mk(32'h20,  0, 4'hF, 0, 1'(k / 4 + 1),  32'h1122_CCDD, 0);
        2:       rd8[k] = mk(32'hFFC, 0, 4'hF, 0, 1'(k / 4),      32'hCAFE_F00D, 0);
        default: rd8[k] = mk(32'h14,  0, 4'hF, 0, 1'(k / 4 + 1),  32'h0000_005A, 0);
      endcase
    end

    for (int i = 0; i < 1024; i++) sram[i] = '0;
    sram_rdata = '0;

    // Reset state, with a request pending to prove the grant is masked.
    rst = 1'b1; req = 1'b1; addr = 32'h10; we = 1'b0; be = 4'hF; wdata = '0; aid = '0;
    r_ready = 1'b1;
    #12;
    check("reset gnt", 32'(gnt), 0);
    check("reset r_valid", 32'(r_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset sram_req", 32'(sram_req), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("first cycle after reset gnt", 32'(gnt), 0);
    @(posedge clk); #1;

    run_single(mk(32'h10, 1, 4'hF, 32'hDEAD_BEEF, 1, 32'h0, 0), "write latency");
    run_single(mk(32'h10, 0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 0), "read latency");

    // Table vectors issued back-to-back with r_ready high.
    for (int k = 0; k < 13; k++) issue(tbl[k], 1'b1, t);
    req = 1'b0;
    wait_idle();

    // Eight back-to-back reads: responses on consecutive cycles from T+2.
    pop_cyc.delete();
    t0 = 0;
    for (int k = 0; k < 8; k++) begin
      issue(rd8[k], 1'b1, t);
      if (k == 0) t0 = t;
    end
    req = 1'b0;
    wait_idle();
    check("b2b response count", pop_cyc.size(), 8);
    for (int k = 0; k < pop_cyc.size(); k++)
      check("b2b response cycle", 32'(pop_cyc[k] - t0), 32'(k + 2));

    // Back-pressure: two grants, then gnt low and head stable until r_ready rises.
    r_ready = 1'b0;
    req = 1'b1; addr = 32'h10; we = 1'b0; be = 4'hF; wdata = '0; aid = 1'b1;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt) begin
        grants++;
        if (addr == 32'h10) sb.push_back('{rdata: 32'hDEAD_BEEF, rid: 1'b1, err: 1'b0});
        else                sb.push_back('{rdata: 32'h1122_CCDD, rid: 1'b0, err: 1'b0});
      end
      if (i >= 2) begin
        check("stall gnt low", 32'(gnt), 0);
        check("stall r_valid", 32'(r_valid), 1);
        check("stall head rdata", rdata, 32'hDEAD_BEEF);
        check("stall head rid", 32'(rid), 1);
      end
      @(posedge clk); #1;
      if (grants == 1) begin addr = 32'h20; aid = 1'b0; end
    end
    check("stall grant count", grants, 2);
    r_ready = 1'b1;
    @(negedge clk);
    check("gnt on r_ready rise", 32'(gnt), 1);
    if (gnt) sb.push_back('{rdata: 32'h1122_CCDD, rid: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle();

    // Reset with two responses buffered drops them asynchronously.
    r_ready = 1'b0;
    issue(rd8[0], 1'b1, t);
    issue(rd8[1], 1'b1, t);
    req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req = 1'b1; r_ready = 1'b1;
    #1;
    check("pre-reset r_valid", 32'(r_valid), 1);
    check("pre-reset busy", 32'(busy), 1);
    check("pre-reset gnt", 32'(gnt), 1);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    check("async reset r_valid", 32'(r_valid), 0);
    check("async reset busy", 32'(busy), 0);
    check("async reset gnt", 32'(gnt), 0);
    check("async reset sram_req", 32'(sram_req), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset first cycle gnt", 32'(gnt), 0);
    @(posedge clk); #1;
    run_single(mk(32'h10, 0, 4'hF, 32'h0, 1, 32'hDEAD_BEEF, 0), "read after reset latency");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
